// File: rtl/asteroid_scheduler.sv
// asteroid_scheduler: spawns asteroid instances into free slots on a frame
// timer, tracks which slots are active, and arbitrates the per-slot pixel
// streams down to a single drawing/pixel pair.
// Optional feature: define ASTEROID_SPEED_RAMP_EN to ramp the speed output
// after every SPEED_STEP successful spawns (saturating at SPEED_MAX).
module asteroid_scheduler #(
    parameter int SLOTS          = 8,
    parameter int SPAWN_INTERVAL = 60,
    parameter int SPEED_STEP     = 16,
    parameter int SPEED_MAX      = 7,
    parameter int COLR_BITS      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame,
    input  logic [SLOTS-1:0]           retire,
    input  logic [SLOTS-1:0]           ast_drawing,
    input  logic [SLOTS*COLR_BITS-1:0] ast_pixel,
    output logic [SLOTS-1:0]           enabled,
    output logic [SLOTS-1:0]           spawn,
    output logic [15:0]                spawn_id,
    output logic [2:0]                 speed,
    output logic                       full,
    output logic                       drawing,
    output logic [COLR_BITS-1:0]       pixel
);

    localparam int TW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(SPAWN_INTERVAL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        SPAWN  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TW-1:0]     timer;
    logic [15:0]       id_cnt;
    logic [SW-1:0]     free_idx;
    logic              free_found;
    logic [SLOTS-1:0]  spawn_set;
    logic              arb_found;
    logic [COLR_BITS-1:0] arb_pixel;

    // Lowest-index free slot, evaluated against the current enabled vector.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!free_found && !enabled[i]) begin
                free_found = 1'b1;
                free_idx   = SW'(i);
            end
        end
    end

    // Next-state logic for the spawn sequencer.
    always_comb begin
        state_nxt = state;
        spawn_set = '0;
        case (state)
            IDLE:    if (frame && timer == '0) state_nxt = SEARCH;
            SEARCH:  state_nxt = free_found ? SPAWN : IDLE;
            SPAWN: begin
                state_nxt = IDLE;
                spawn_set = spawn;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Timer, slot bookkeeping and the spawn strobe. The strobe register also
    // serves as the latched slot, so enabled is set from it in SPAWN; OR-ing
    // after the retire mask lets a same-cycle spawn win over retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer    <= TIMER_RELOAD;
            enabled  <= '0;
            spawn    <= '0;
            spawn_id <= '0;
            id_cnt   <= '0;
            full     <= 1'b0;
        end else begin
            spawn   <= '0;
            enabled <= (enabled & ~retire) | spawn_set;
            case (state)
                IDLE: begin
                    if (frame && timer != '0) timer <= timer - 1'b1;
                end
                SEARCH: begin
                    if (free_found) begin
                        spawn    <= SLOTS'(1) << free_idx;
                        spawn_id <= id_cnt;
                    end else begin
                        full  <= 1'b1;
                        timer <= '0;
                    end
                end
                SPAWN: begin
                    id_cnt <= id_cnt + 16'd1;
                    timer  <= TIMER_RELOAD;
                    full   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef ASTEROID_SPEED_RAMP_EN
    localparam int SCW = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;

    logic [SCW-1:0] spawn_cnt;

    // Count successful spawns and bump speed every SPEED_STEP of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            spawn_cnt <= '0;
            speed     <= 3'd1;
        end else if (state == SPAWN) begin
            if (spawn_cnt == SCW'(SPEED_STEP - 1)) begin
                spawn_cnt <= '0;
                if (speed < 3'(SPEED_MAX)) speed <= speed + 3'd1;
            end else begin
                spawn_cnt <= spawn_cnt + 1'b1;
            end
        end
    end
`else
    assign speed = 3'd1;
`endif

    // Priority pick of the lowest-index active slot that is drawing.
    always_comb begin
        arb_found = 1'b0;
        arb_pixel = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!arb_found && ast_drawing[i] && enabled[i]) begin
                arb_found = 1'b1;
                arb_pixel = ast_pixel[i*COLR_BITS +: COLR_BITS];
            end
        end
    end

    // Registered arbiter output.
    always_ff @(posedge clk) begin
        if (rst) begin
            drawing <= 1'b0;
            pixel   <= '0;
        end else begin
            drawing <= arb_found;
            pixel   <= arb_pixel;
        end
    end

endmodule

// File: doc/asteroid_scheduler.md
ASTEROID_SCHEDULER -- requirements
Module: asteroid_scheduler

Interface
REQ-001 SHALL have parameter SLOTS, default 8: number of asteroid instances managed.
REQ-002 SHALL have parameter SPAWN_INTERVAL, default 60: frames between spawn attempts (min 1).
REQ-003 SHALL have parameter SPEED_STEP, default 16: successful spawns per speed increment.
REQ-004 SHALL have parameter SPEED_MAX, default 7: speed saturation value.
REQ-005 SHALL have parameter COLR_BITS, default 4: pixel colour width.
REQ-006 SHALL have port clk  in  1  system clock; single clock domain.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port frame  in  1  one-cycle pulse per frame.
REQ-009 SHALL have port retire  in  SLOTS  per-slot request to free the slot (shot or off-screen).
REQ-010 SHALL have port ast_drawing  in  SLOTS  per-slot drawing flag from asteroid instances.
REQ-011 SHALL have port ast_pixel  in  SLOTS*COLR_BITS  per-slot pixel; slot i at bits [i*COLR_BITS +: COLR_BITS].
REQ-012 SHALL have port enabled  out  SLOTS  slot-active bits.
REQ-013 SHALL have port spawn  out  SLOTS  one-hot, one-cycle spawn strobe.
REQ-014 SHALL have port spawn_id  out  16  id for the spawned asteroid, valid while spawn!=0.
REQ-015 SHALL have port speed  out  3  current asteroid speed.
REQ-016 SHALL have port full  out  1  last spawn attempt found no free slot.
REQ-017 SHALL have port drawing  out  1  arbitrated drawing flag.
REQ-018 SHALL have port pixel  out  COLR_BITS  arbitrated pixel.

Function
REQ-019 SHALL implement FSM states IDLE, SEARCH, SPAWN.
REQ-020 IDLE: on frame with timer!=0 SHALL decrement timer; on frame with timer==0 SHALL go to SEARCH.
REQ-021 SEARCH: SHALL latch lowest-index slot with enabled==0 and go to SPAWN; if none, SHALL set full=1, hold timer at 0, return to IDLE (retry next frame).
REQ-022 SPAWN: SHALL set enabled[slot], pulse spawn[slot] for exactly one cycle, drive spawn_id=id counter, increment id counter (wraps 16'hFFFF->0), reload timer with SPAWN_INTERVAL-1, clear full, return to IDLE.
REQ-023 Spawn strobe SHALL occur exactly 2 cycles after the triggering frame pulse.
REQ-024 frame pulses arriving in SEARCH or SPAWN SHALL be ignored.
REQ-025 retire[i] SHALL clear enabled[i] the next cycle in any state; retire of a disabled slot SHALL be ignored.
REQ-026 Retire and spawn on the same slot in the same cycle: spawn SHALL win (enabled=1).
REQ-027 A slot retired during SEARCH SHALL become eligible at the next SEARCH only.
REQ-028 Arbiter SHALL register, each cycle, the lowest-index i with ast_drawing[i]&enabled[i]: drawing=1, pixel=ast_pixel slot i; none -> drawing=0, pixel=0; latency 1 cycle.

Reset
REQ-029 On rst SHALL set: state IDLE, timer=SPAWN_INTERVAL-1, enabled=0, spawn=0, spawn_id=0, id counter=0, spawn count=0, speed=1, full=0, drawing=0, pixel=0.
REQ-030 rst mid-operation (SEARCH/SPAWN) SHALL abort the spawn with no spawn strobe.

Configuration
REQ-031 With ASTEROID_SPEED_RAMP_EN defined, speed SHALL increment after every SPEED_STEP successful spawns, saturating at SPEED_MAX.
REQ-032 Without ASTEROID_SPEED_RAMP_EN, speed SHALL stay 1 and the spawn counter SHALL be omitted.

Verification (SLOTS=4, SPAWN_INTERVAL=2, SPEED_STEP=2, SPEED_MAX=3)
REQ-033 Reset then 2 frame pulses -> spawn=4'b0001, spawn_id=0, two cycles after 2nd frame; enabled=4'b0001.
REQ-034 Continue 6 more frames, no retires -> spawns on slots 1,2,3 with ids 1,2,3; next attempt sets full=1, no strobe.
REQ-035 With all full, retire=4'b0100 then 2 frames -> spawn=4'b0100, id=4, full=0.
REQ-036 Ramp enabled: after 2 spawns speed=2, after 4 speed=3, after 6 still 3; ramp disabled: speed=1 throughout.
REQ-037 ast_drawing=4'b0110 with slots 1,2 enabled, ast_pixel slot1=4'hA slot2=4'h5 -> next cycle drawing=1, pixel=4'hA; slot 1 disabled -> pixel=4'h5.
REQ-038 rst asserted in the SEARCH cycle -> no spawn strobe, all outputs at reset values next cycle.
